// File: rtl/tpg_lfsr_vecgen.sv
// tpg_lfsr_vecgen
//   Pseudo-random test-pattern generator feeding the c880 fault-simulation
//   stage. A seedable 60-bit Fibonacci LFSR (x^60 + x^59 + 1) supplies
//   vectors over a valid/ready handshake. The generator counts accepted
//   vectors and stops when it reaches a limit that is captured at start.
//
//   Optional feature: define TPG_WEIGHTED_EN to OR lfsr[(i+7)%WIDTH] into
//   every output bit i whose WEIGHT_MASK bit is set. Those bits are then
//   1 with a probability of about 0.75. The LFSR sequence does not change.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   start         pulse: begin a run (acted on in IDLE/DONE)
//   abort         pulse: stop the run and return to IDLE
//   seed_load     load seed_in into the LFSR (IDLE/DONE only; 0 -> SEED)
//   seed_in       seed value
//   max_vectors   vectors per run, captured at start; 0 emits none
//   vec_valid     test_vector is valid
//   vec_ready     consumer accepts the vector this cycle
//   test_vector   current vector; bit WIDTH-1 drives g[1], bit 0 drives g[60]
//   vec_index     vectors accepted in the current run
//   done          run complete; held until the next start
module tpg_lfsr_vecgen #(
  parameter int unsigned        WIDTH       = 60,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [WIDTH-1:0]   SEED        = 60'h1,
  parameter logic [WIDTH-1:0]   WEIGHT_MASK = 60'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] max_vectors,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] test_vector,
  output logic [CNT_W-1:0] vec_index,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [CNT_W-1:0] maxReg;
  logic [CNT_W-1:0] vecIndex;
  logic             vecValid;
  logic             doneReg;

  // Carry the extra bit so that the compare with the limit cannot wrap.
  logic [CNT_W:0]   idxNext;
  logic             handshake;
  logic [WIDTH-1:0] lfsrAdv;

  assign idxNext   = {1'b0, vecIndex} + {{CNT_W{1'b0}}, 1'b1};
  assign handshake = vecValid & vec_ready;
  assign lfsrAdv   = {lfsr[WIDTH-2:0], lfsr[WIDTH-1] ^ lfsr[WIDTH-2]};

  assign vec_valid = vecValid;
  assign vec_index = vecIndex;
  assign done      = doneReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr     <= SEED;
      maxReg   <= '0;
      vecIndex <= '0;
      vecValid <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // The seed load and the start take effect together. A vector
          // started in the same cycle is therefore the newly loaded seed.
          if (seed_load)
            lfsr <= (seed_in == '0) ? SEED : seed_in;
          if (start) begin
            vecIndex <= '0;
            maxReg   <= max_vectors;
            if (max_vectors == '0) begin
              state   <= DONE;
              doneReg <= 1'b1;
            end else begin
              state    <= GEN;
              vecValid <= 1'b1;
              doneReg  <= 1'b0;
            end
          end else if (abort) begin
            state   <= IDLE;
            doneReg <= 1'b0;
          end
        end
        GEN: begin
          // An abort wins over a handshake in the same cycle. That vector
          // is not counted and the LFSR keeps its value.
          if (abort) begin
            state    <= IDLE;
            vecValid <= 1'b0;
          end else if (handshake) begin
            lfsr <= lfsrAdv;
            if (vecIndex != '1)
              vecIndex <= idxNext[CNT_W-1:0];
            if (idxNext == {1'b0, maxReg}) begin
              state    <= DONE;
              vecValid <= 1'b0;
              doneReg  <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          vecValid <= 1'b0;
          doneReg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TPG_WEIGHTED_EN
  // Output bits with their mask bit set OR in a second LFSR tap, which
  // raises P(1) to about 0.75. Each output bit is generated separately.
  for (genvar i = 0; i < WIDTH; i++) begin : gWeight
    if (WEIGHT_MASK[i]) begin : gOr
      assign test_vector[i] = lfsr[i] | lfsr[(i + 7) % WIDTH];
    end else begin : gPass
      assign test_vector[i] = lfsr[i];
    end
  end
`else
  assign test_vector = lfsr;
`endif

endmodule

// File: tb/tb_tpg_lfsr_vecgen.sv
module tb_tpg_lfsr_vecgen;

  localparam int          WIDTH = 60;
  localparam int          CNT_W = 16;
  localparam logic [59:0] SEEDV = 60'h1;
  localparam logic [59:0] WMASK = 60'h1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, seed_load, vec_ready;
  logic [WIDTH-1:0]  seed_in;
  logic [CNT_W-1:0]  max_vectors;
  logic              vec_valid, done;
  logic [WIDTH-1:0]  test_vector;
  logic [CNT_W-1:0]  vec_index;

  int nAssert = 0;
  int nFail   = 0;

  tpg_lfsr_vecgen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEED(SEEDV), .WEIGHT_MASK(WMASK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .seed_load(seed_load), .seed_in(seed_in), .max_vectors(max_vectors),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .test_vector(test_vector),
    .vec_index(vec_index), .done(done)
  );

  always #5 clk = ~clk;

  // Reference LFSR step: shift left by one and feed bit59 XOR bit58 into
  // bit 0.
  function automatic logic [59:0] lfsrNext(input logic [59:0] v);
    logic [63:0] w;
    logic        fb;
    w  = {4'b0, v};
    fb = ((w >> 59) & 64'h1) != ((w >> 58) & 64'h1);
    w  = ((w << 1) & 64'h0FFF_FFFF_FFFF_FFFF) | {63'b0, fb};
    return w[59:0];
  endfunction

  function automatic logic [59:0] expVec(input logic [59:0] v);
    logic [59:0] r;
    r = v;
`ifdef TPG_WEIGHTED_EN
    for (int i = 0; i < 60; i++)
      if (WMASK[i]) r[i] = v[i] | v[(i + 7) % 60];
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [59:0] m;      // model LFSR
  int          mx, cnt, cyc;
  logic        rdy;

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; seed_load = 0; vec_ready = 0;
    seed_in = '0; max_vectors = '0;
    m = SEEDV;
    #12;
    chk("rst_valid", {63'b0, vec_valid}, 64'd0);
    chk("rst_done",  {63'b0, done}, 64'd0);
    chk("rst_index", {48'b0, vec_index}, 64'd0);
    chk("rst_vec",   {4'b0, test_vector}, {4'b0, expVec(SEEDV)});
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic run: 4 vectors at full throughput
    start = 1; max_vectors = 4; vec_ready = 1;
    tick(); start = 0;
    for (int k = 0; k < 4; k++) begin
      chk("basic_valid", {63'b0, vec_valid}, 64'd1);
      chk("basic_vec", {4'b0, test_vector}, {4'b0, expVec(m)});
      tick(); m = lfsrNext(m);
    end
    chk("basic_done", {63'b0, done}, 64'd1);
    chk("basic_vvalid0", {63'b0, vec_valid}, 64'd0);
    chk("basic_index", {48'b0, vec_index}, 64'd4);
    chk("basic_m8", {4'b0, m}, 64'h10);

    // Backpressure: restart from the seed
    rst_n = 0; #1; rst_n = 1; m = SEEDV;
    start = 1; max_vectors = 3; vec_ready = 0;
    tick(); start = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_vec", {4'b0, test_vector}, 64'h1);
      chk("bp_hold_valid", {63'b0, vec_valid}, 64'd1);
      tick();
    end
    vec_ready = 1;
    tick(); m = lfsrNext(m);
    chk("bp_second", {4'b0, test_vector}, 64'h2);
    tick(); m = lfsrNext(m);
    tick(); m = lfsrNext(m);
    chk("bp_done", {63'b0, done}, 64'd1);
    chk("bp_index", {48'b0, vec_index}, 64'd3);

    // Seed load in DONE, then start
    seed_load = 1; seed_in = 60'hC00000000000000;
    tick(); seed_load = 0; m = 60'hC00000000000000;
    start = 1; max_vectors = 2;
    tick(); start = 0;
    chk("seed_v0", {4'b0, test_vector}, {4'b0, expVec(60'hC00000000000000)});
    tick(); m = lfsrNext(m);
    chk("seed_v1", {4'b0, test_vector}, {4'b0, expVec(60'h800000000000000)});
    tick(); m = lfsrNext(m);
    chk("seed_done", {63'b0, done}, 64'd1);
    // Zero seed plus start in the same cycle -> first vector is SEED
    seed_load = 1; seed_in = '0; start = 1; max_vectors = 1;
    tick(); seed_load = 0; start = 0; m = SEEDV;
    chk("seed0_vec", {4'b0, test_vector}, 64'h1);
    seed_load = 1; seed_in = 60'h123;
    tick(); seed_load = 0; m = lfsrNext(m);
    chk("seed_gen_ign_done", {63'b0, done}, 64'd1);
    chk("seed_gen_ign_lfsr", {4'b0, dut.test_vector}, {4'b0, expVec(m)});

    // Abort on the 3rd handshake
    rst_n = 0; #1; rst_n = 1; m = SEEDV;
    start = 1; max_vectors = 10; vec_ready = 1;
    tick(); start = 0;
    tick(); m = lfsrNext(m);
    tick(); m = lfsrNext(m);
    chk("ab_pre_vec", {4'b0, test_vector}, 64'h4);
    abort = 1;
    tick(); abort = 0;
    chk("ab_valid", {63'b0, vec_valid}, 64'd0);
    chk("ab_index", {48'b0, vec_index}, 64'd2);
    chk("ab_done", {63'b0, done}, 64'd0);
    tick();
    chk("ab_idle_vec", {4'b0, test_vector}, 64'h4);
    start = 1; max_vectors = 3;
    tick(); start = 0;
    chk("ab_resume_vec", {4'b0, test_vector}, 64'h4);
    chk("ab_resume_idx", {48'b0, vec_index}, 64'd0);
    for (int k = 0; k < 3; k++) begin tick(); m = lfsrNext(m); end
    chk("ab_run_done", {63'b0, done}, 64'd1);

    // Zero limit, then a single vector
    start = 1; max_vectors = 0;
    tick(); start = 0;
    chk("z_done", {63'b0, done}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("z_novalid", {63'b0, vec_valid}, 64'd0);
      tick();
    end
    start = 1; max_vectors = 1;
    tick(); start = 0;
    chk("one_valid", {63'b0, vec_valid}, 64'd1);
    chk("one_done0", {63'b0, done}, 64'd0);
    chk("one_vec", {4'b0, test_vector}, {4'b0, expVec(m)});
    tick(); m = lfsrNext(m);
    chk("one_done", {63'b0, done}, 64'd1);
    chk("one_idx", {48'b0, vec_index}, 64'd1);

    // Randomized runs with random backpressure and random reseeds
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        seed_load = 1;
        seed_in = {$urandom, $urandom} & 60'hFFF_FFFF_FFFF_FFFF;
        if ($urandom_range(0, 4) == 0) seed_in = '0;
        tick(); seed_load = 0;
        m = (seed_in == '0) ? SEEDV : seed_in;
      end
      mx = $urandom_range(1, 20);
      start = 1; max_vectors = mx[CNT_W-1:0];
      tick(); start = 0;
      max_vectors = $urandom;   // ignored mid-run
      cnt = 0; cyc = 0;
      while (cnt < mx && cyc < 400) begin
        chk("rnd_valid", {63'b0, vec_valid}, 64'd1);
        chk("rnd_vec", {4'b0, test_vector}, {4'b0, expVec(m)});
        chk("rnd_idx", {48'b0, vec_index}, cnt);
        rdy = $urandom_range(0, 1);
        vec_ready = rdy;
        tick();
        if (rdy) begin m = lfsrNext(m); cnt++; end
        cyc++;
      end
      chk("rnd_budget", {63'b0, (cyc < 400)}, 64'd1);
      chk("rnd_done", {63'b0, done}, 64'd1);
      chk("rnd_vvalid0", {63'b0, vec_valid}, 64'd0);
      chk("rnd_final_idx", {48'b0, vec_index}, mx);
    end

    // Asynchronous reset in the middle of a run
    vec_ready = 0; start = 1; max_vectors = 5;
    tick(); start = 0;
    #2 rst_n = 0; #1;
    chk("arst_valid", {63'b0, vec_valid}, 64'd0);
    chk("arst_vec", {4'b0, test_vector}, {4'b0, expVec(SEEDV)});
    chk("arst_idx", {48'b0, vec_index}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    rst_n = 1;

`ifdef TPG_WEIGHTED_EN
    // Weighting: LFSR = 0x80 -> bit 0 = bit 7
    seed_load = 1; seed_in = 60'h80;
    tick(); seed_load = 0;
    chk("w_bit0", {63'b0, test_vector[0]}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
